sample_wdt_reset_req: RTL and testbench
=======================================

// Module: sample_wdt_reset_req
// PURPOSE
//  Watchdog / reset-request source feeding the active-low reset request input of the POR block.
//  Counts clock48 cycles while enabled. Firmware must kick the counter before it expires.
//  On expiry or on a software request it drives reseted_out low for HOLD_CLOCKS cycles.
//  It then waits for the POR handshake: resetn_out must go low, then high again. It records the cause.
// PARAMETERS
//  WARN_CLOCKS     36000000  cycles in RUN before warn_irq asserts (1 <= WARN < TIMEOUT)
//  TIMEOUT_CLOCKS  48000000  cycles from entering RUN (no kick) to reseted_out low
//  HOLD_CLOCKS     800       width of reseted_out low pulse, cycles (>=1)
//  ACK_CLOCKS      4096      max COOLDOWN cycles waiting for POR handshake (>=1)
// PORTS
//  clock48      in   1   system clock
//  reset        in   1   synchronous, active-high reset
//  enable       in   1   watchdog enable (level)
//  kick         in   1   1-cycle pulse: restart count
//  sw_req       in   1   1-cycle pulse: immediate reset request
//  por_resetn   in   1   resetn_out of POR (handshake input), already in clock48 domain
//  reseted_out  out  1   active-low reset request to POR
//  warn_irq     out  1   high in WARN state
//  last_cause   out  2   00 none, 01 timeout, 10 software, 11 ack timeout
//  state_out    out  3   current FSM state encoding (below)
//  count_out    out  32  current counter value
// BEHAVIOUR
//  All outputs are registered. Reset values: reseted_out=1, warn_irq=0, last_cause=00, state=IDLE, count=0.
//  States: IDLE=0, RUN=1, WARN=2, FIRE=3, COOLDOWN=4. Remaining encodings go to IDLE on the next edge.
//  IDLE: count=0. Enters RUN with count=0 when enable && por_resetn.
//  RUN: count+1 per cycle. kick -> count=0.
//   If count==WARN_CLOCKS-1 and no kick -> WARN, warn_irq=1.
//  WARN: count+1 per cycle. kick -> count=0, RUN, warn_irq=0.
//   If count==TIMEOUT_CLOCKS-1 and no kick -> FIRE, last_cause=01.
//  Resulting timing: reseted_out falls exactly TIMEOUT_CLOCKS edges after RUN entry when there are no kicks.
//  sw_req in IDLE/RUN/WARN -> FIRE on the next edge, last_cause=10. This applies even when enable=0.
//  Priority in RUN/WARN: sw_req > kick > threshold. A kick on the threshold cycle suppresses the transition.
//  enable=0 or por_resetn=0 in RUN/WARN (no sw_req) -> IDLE, count=0, warn_irq=0.
//  FIRE: reseted_out=0 and warn_irq=0. count restarts at 0 and counts HOLD_CLOCKS cycles.
//   Then COOLDOWN with reseted_out=1 and count=0.
//   kick, sw_req, enable and por_resetn are ignored in FIRE.
//  COOLDOWN: sticky flag seen_low is set when por_resetn==0.
//   por_resetn==1 with seen_low -> IDLE.
//   count reaches ACK_CLOCKS-1 without completion -> IDLE, last_cause=11.
//   sw_req and kick are ignored in COOLDOWN.
//  last_cause persists until the next FIRE or until reset. A FIRE overwrites it.
//  Reset asserted in any state, including mid-pulse, returns to IDLE with reseted_out=1 on the same edge.
//  count is 32 bit and never wraps, because all parameters are below 2^32-1.
// TESTING (WARN=10, TIMEOUT=20, HOLD=4, ACK=50)
//  1. enable=1, por_resetn=1, no kicks -> warn_irq=1 at edge 10.
//     reseted_out=0 at edges 20..23, =1 at edge 24; last_cause=01.
//  2. Kick every 8 cycles for 200 cycles -> warn_irq stays 0, reseted_out stays 1, count_out never exceeds 8.
//  3. Kick on the same cycle count==19 in WARN -> state returns to RUN with count 0, no FIRE.
//  4. sw_req with enable=0 -> reseted_out low 4 cycles, last_cause=10.
//     Then por_resetn low 3 cycles and back high -> IDLE.
//  5. FIRE with por_resetn held 1 -> COOLDOWN times out after 50 cycles, last_cause=11, state IDLE.
//  6. Assert reset at the 2nd FIRE cycle -> reseted_out=1 and state IDLE next edge; last_cause=00.

Source files
------------

// File: rtl/sample_wdt_reset_req.sv
// Purpose : watchdog and reset-request source driving the active-low reset request input of the POR block.
// Latency : all outputs registered; a state change shows on the outputs at the edge that takes it.
// Backpr. : none. kick/sw_req are single-cycle pulses sampled every edge; the POR handshake is waited for in COOLDOWN.
//
// Ports
//   clock48      in   1   system clock
//   reset        in   1   synchronous active-high reset
//   enable       in   1   watchdog enable (level)
//   kick         in   1   1-cycle pulse, restarts the count in RUN/WARN
//   sw_req       in   1   1-cycle pulse, immediate reset request from IDLE/RUN/WARN
//   por_resetn   in   1   resetn_out of the POR block, already in the clock48 domain
//   reseted_out  out  1   active-low reset request to the POR block
//   warn_irq     out  1   high while in WARN
//   last_cause   out  2   00 none, 01 timeout, 10 software, 11 ack timeout
//   state_out    out  3   IDLE=0 RUN=1 WARN=2 FIRE=3 COOLDOWN=4
//   count_out    out  32  current cycle counter

module sample_wdt_reset_req #(
   parameter int unsigned WARN_CLOCKS    = 36000000,
   parameter int unsigned TIMEOUT_CLOCKS = 48000000,
   parameter int unsigned HOLD_CLOCKS    = 800,
   parameter int unsigned ACK_CLOCKS     = 4096
) (
   input  logic        clock48,
   input  logic        reset,
   input  logic        enable,
   input  logic        kick,
   input  logic        sw_req,
   input  logic        por_resetn,
   output logic        reseted_out,
   output logic        warn_irq,
   output logic [1:0]  last_cause,
   output logic [2:0]  state_out,
   output logic [31:0] count_out
);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RUN      = 3'd1,
      ST_WARN     = 3'd2,
      ST_FIRE     = 3'd3,
      ST_COOLDOWN = 3'd4
   } wdt_state_t;

   localparam logic [1:0] CAUSE_NONE    = 2'b00;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'b01;
   localparam logic [1:0] CAUSE_SW      = 2'b10;
   localparam logic [1:0] CAUSE_ACK     = 2'b11;

   // Terminal counts. The counter keeps running from RUN into WARN, so the
   // timeout compare is against the absolute count since RUN entry.
   localparam logic [31:0] WARN_LAST    = 32'(WARN_CLOCKS - 1);
   localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CLOCKS - 1);
   localparam logic [31:0] HOLD_LAST    = 32'(HOLD_CLOCKS - 1);
   localparam logic [31:0] ACK_LAST     = 32'(ACK_CLOCKS - 1);

   wdt_state_t  state_q, state_d;
   logic [31:0] count_q, count_d;
   logic        reseted_q, reseted_d;
   logic        warn_q, warn_d;
   logic [1:0]  cause_q, cause_d;
   logic        seen_low_q, seen_low_d;

   //------------------------------------------------------------------
   // State register
   //------------------------------------------------------------------
   always_ff @(posedge clock48) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         count_q    <= 32'd0;
         reseted_q  <= 1'b1;
         warn_q     <= 1'b0;
         cause_q    <= CAUSE_NONE;
         seen_low_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         reseted_q  <= reseted_d;
         warn_q     <= warn_d;
         cause_q    <= cause_d;
         seen_low_q <= seen_low_d;
      end
   end

   //------------------------------------------------------------------
   // Next-state and next-output logic
   //------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      reseted_d  = 1'b1;
      warn_d     = warn_q;
      cause_d    = cause_q;
      seen_low_d = seen_low_q;

      case (state_q)
         ST_IDLE: begin
            count_d    = 32'd0;
            warn_d     = 1'b0;
            seen_low_d = 1'b0;
            // A software request fires even with the watchdog disabled.
            if (sw_req) begin
               state_d   = ST_FIRE;
               cause_d   = CAUSE_SW;
               reseted_d = 1'b0;
            end else if (enable && por_resetn) begin
               state_d = ST_RUN;
            end
         end

         ST_RUN: begin
            if (sw_req) begin
               state_d   = ST_FIRE;
               cause_d   = CAUSE_SW;
               reseted_d = 1'b0;
               count_d   = 32'd0;
               warn_d    = 1'b0;
            end else if (!enable || !por_resetn) begin
               state_d = ST_IDLE;
               count_d = 32'd0;
               warn_d  = 1'b0;
            end else if (kick) begin
               count_d = 32'd0;
            end else if (count_q == WARN_LAST) begin
               state_d = ST_WARN;
               warn_d  = 1'b1;
               count_d = count_q + 32'd1;
            end else begin
               count_d = count_q + 32'd1;
            end
         end

         ST_WARN: begin
            if (sw_req) begin
               state_d   = ST_FIRE;
               cause_d   = CAUSE_SW;
               reseted_d = 1'b0;
               count_d   = 32'd0;
               warn_d    = 1'b0;
            end else if (!enable || !por_resetn) begin
               state_d = ST_IDLE;
               count_d = 32'd0;
               warn_d  = 1'b0;
            end else if (kick) begin
               // A kick on the timeout cycle still wins over the threshold.
               state_d = ST_RUN;
               count_d = 32'd0;
               warn_d  = 1'b0;
            end else if (count_q == TIMEOUT_LAST) begin
               state_d   = ST_FIRE;
               cause_d   = CAUSE_TIMEOUT;
               reseted_d = 1'b0;
               count_d   = 32'd0;
               warn_d    = 1'b0;
            end else begin
               count_d = count_q + 32'd1;
            end
         end

         ST_FIRE: begin
            // Inputs are deliberately ignored so the pulse always has full width.
            warn_d = 1'b0;
            if (count_q == HOLD_LAST) begin
               state_d    = ST_COOLDOWN;
               count_d    = 32'd0;
               seen_low_d = 1'b0;
            end else begin
               reseted_d = 1'b0;
               count_d   = count_q + 32'd1;
            end
         end

         ST_COOLDOWN: begin
            // Handshake completes on the first high por_resetn after a low was
            // seen on an earlier cycle; seen_low_q is the registered record.
            if (!por_resetn) begin
               seen_low_d = 1'b1;
            end
            if (por_resetn && seen_low_q) begin
               state_d = ST_IDLE;
               count_d = 32'd0;
            end else if (count_q == ACK_LAST) begin
               state_d = ST_IDLE;
               count_d = 32'd0;
               cause_d = CAUSE_ACK;
            end else begin
               count_d = count_q + 32'd1;
            end
         end

         default: begin
            // Unused encodings recover to IDLE.
            state_d    = ST_IDLE;
            count_d    = 32'd0;
            warn_d     = 1'b0;
            seen_low_d = 1'b0;
         end
      endcase
   end

   assign reseted_out = reseted_q;
   assign warn_irq    = warn_q;
   assign last_cause  = cause_q;
   assign state_out   = state_q;
   assign count_out   = count_q;

endmodule

// File: tb/tb_sample_wdt_reset_req.sv
module tb_sample_wdt_reset_req;

   logic        clock48 = 1'b0;
   logic        reset;
   logic        enable;
   logic        kick;
   logic        sw_req;
   logic        por_resetn;
   logic        reseted_out;
   logic        warn_irq;
   logic [1:0]  last_cause;
   logic [2:0]  state_out;
   logic [31:0] count_out;

   int checks = 0;
   int errors = 0;

   sample_wdt_reset_req #(
      .WARN_CLOCKS    (10),
      .TIMEOUT_CLOCKS (20),
      .HOLD_CLOCKS    (4),
      .ACK_CLOCKS     (50)
   ) dut (
      .clock48     (clock48),
      .reset       (reset),
      .enable      (enable),
      .kick        (kick),
      .sw_req      (sw_req),
      .por_resetn  (por_resetn),
      .reseted_out (reseted_out),
      .warn_irq    (warn_irq),
      .last_cause  (last_cause),
      .state_out   (state_out),
      .count_out   (count_out)
   );

   always #5 clock48 = ~clock48;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   // One rising edge; inputs change and outputs are sampled at the falling edge.
   task automatic tick(input int n = 1);
      repeat (n) @(negedge clock48);
   endtask

   int max_cnt;
   int warn_seen;
   int low_seen;

   initial begin
      reset = 1'b1; enable = 1'b0; kick = 1'b0; sw_req = 1'b0; por_resetn = 1'b1;
      tick(2);
      chk("rst_state",   state_out,   0);
      chk("rst_count",   count_out,   0);
      chk("rst_reseted", reseted_out, 1);
      chk("rst_warn",    warn_irq,    0);
      chk("rst_cause",   last_cause,  0);
      reset = 1'b0;

      // 1: free-running timeout
      enable = 1'b1;
      tick();                            // edge 0: RUN entry
      chk("t1_run",      state_out, 1);
      chk("t1_cnt0",     count_out, 0);
      tick(9);                           // edge 9
      chk("t1_warn_pre", warn_irq, 0);
      chk("t1_cnt9",     count_out, 9);
      tick();                            // edge 10
      chk("t1_warn",     warn_irq, 1);
      chk("t1_st_warn",  state_out, 2);
      tick(9);                           // edge 19
      chk("t1_rst_pre",  reseted_out, 1);
      tick();                            // edge 20
      chk("t1_fire",     state_out, 3);
      chk("t1_low20",    reseted_out, 0);
      chk("t1_warn_off", warn_irq, 0);
      chk("t1_cause",    last_cause, 1);
      tick(3);                           // edge 23
      chk("t1_low23",    reseted_out, 0);
      chk("t1_cnt23",    count_out, 3);
      tick();                            // edge 24
      chk("t1_high24",   reseted_out, 1);
      chk("t1_cool",     state_out, 4);
      chk("t1_coolcnt",  count_out, 0);
      enable = 1'b0;
      por_resetn = 1'b0;
      tick();
      por_resetn = 1'b1;
      tick();
      chk("t1_idle",     state_out, 0);
      chk("t1_cause_k",  last_cause, 1);

      // 2: regular kicks keep it in RUN
      enable = 1'b1;
      tick();
      chk("t2_run", state_out, 1);
      max_cnt = 0; warn_seen = 0; low_seen = 0;
      for (int i = 0; i < 200; i++) begin
         kick = ((i % 8) == 7);
         tick();
         kick = 1'b0;
         if (int'(count_out) > max_cnt) max_cnt = int'(count_out);
         if (warn_irq) warn_seen++;
         if (!reseted_out) low_seen++;
      end
      chk("t2_maxcnt",   max_cnt,   7);
      chk("t2_warn",     warn_seen, 0);
      chk("t2_low",      low_seen,  0);
      chk("t2_still",    state_out, 1);
      chk("t2_cnt_end",  count_out, 0);

      // 3: kick on the timeout cycle
      tick(10);
      chk("t3_warn",     state_out, 2);
      tick(9);
      chk("t3_cnt19",    count_out, 19);
      kick = 1'b1;
      tick();
      kick = 1'b0;
      chk("t3_run",      state_out, 1);
      chk("t3_cnt0",     count_out, 0);
      chk("t3_nofire",   reseted_out, 1);
      chk("t3_warnoff",  warn_irq, 0);
      chk("t3_cause",    last_cause, 1);
      enable = 1'b0;
      tick();
      chk("t3_idle",     state_out, 0);

      // 4: software request with watchdog disabled, full handshake
      sw_req = 1'b1;
      tick();
      sw_req = 1'b0;
      chk("t4_fire",     state_out, 3);
      chk("t4_low",      reseted_out, 0);
      chk("t4_cause",    last_cause, 2);
      tick(3);
      chk("t4_low4",     reseted_out, 0);
      tick();
      chk("t4_cool",     state_out, 4);
      chk("t4_high",     reseted_out, 1);
      por_resetn = 1'b0;
      tick(3);
      chk("t4_wait",     state_out, 4);
      por_resetn = 1'b1;
      tick();
      chk("t4_idle",     state_out, 0);
      chk("t4_cause_k",  last_cause, 2);

      // 5: handshake never comes
      sw_req = 1'b1;
      tick();
      sw_req = 1'b0;
      tick(4);
      chk("t5_cool",     state_out, 4);
      tick(49);
      chk("t5_cnt49",    count_out, 49);
      chk("t5_still",    state_out, 4);
      tick();
      chk("t5_idle",     state_out, 0);
      chk("t5_cause",    last_cause, 3);

      // 6: reset in the middle of the pulse
      sw_req = 1'b1;
      tick();
      sw_req = 1'b0;
      tick();
      chk("t6_fire2",    count_out, 1);
      chk("t6_low",      reseted_out, 0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("t6_idle",     state_out, 0);
      chk("t6_high",     reseted_out, 1);
      chk("t6_cause",    last_cause, 0);
      chk("t6_cnt",      count_out, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
